sdram_traffic_gen: RTL and testbench

Parametrised self-checking traffic generator for the SDRAM controller's user port. It writes a selectable data pattern over a programmable address window in fixed-length bursts, reads the window back, compares every beat and reports pass/fail, error count and first failing address. It sits between the board/sim top and the SDRAM controller user interface, and replaces the fixed-stimulus approach with one block usable both in simulation against the SDRAM model and on hardware.

---
 rtl/sdram_traffic_gen.sv | 165 ++++++++++++++++
 tb/tb_sdram_traffic_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_traffic_gen.sv
// Self-checking SDRAM traffic generator: writes a pattern over an address window in
// fixed-length bursts, reads it back and reports pass, error count and first bad address.
module sdram_traffic_gen #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 21,
  parameter int BURST_LEN = 8,
  parameter int ERR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_bursts,
  input  logic [DATA_W-1:0] seed,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  input  logic              rd_ack,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data_vld,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BEAT, RD_REQ, RD_BEAT, FIN} state_t;

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BSTEP     = ADDR_W'(BURST_LEN);
  localparam logic [DATA_W-1:0] LFSR_TAPS =
    (DATA_W == 8)  ? DATA_W'(8'hB8) :
    (DATA_W == 16) ? DATA_W'(16'hB400) :
    (DATA_W == 32) ? DATA_W'(32'h8020_0003) : {1'b1, {(DATA_W-1){1'b0}}};

  state_t             state_q;
  logic [1:0]         mode_q;
  logic [ADDR_W-1:0]  base_q, nb_q, addr_q, bcnt_q, ferr_q;
  logic [DATA_W-1:0]  seed_q, pat_q;
  logic [BW-1:0]      beat_q;
  logic [ERR_W-1:0]   err_q;
  logic               pass_q;

  function automatic logic [DATA_W-1:0] pat_init(input logic [1:0] m, input logic [DATA_W-1:0] s);
    case (m)
      2'd2:    pat_init = DATA_W'(1);
      2'd3:    pat_init = (s == '0) ? DATA_W'(1) : s;
      default: pat_init = s;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] pat_next(input logic [1:0] m, input logic [DATA_W-1:0] p);
    case (m)
      2'd0:    pat_next = p + DATA_W'(1);
      2'd2:    pat_next = {p[DATA_W-2:0], p[DATA_W-1]};
      2'd3:    pat_next = (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
      default: pat_next = p;
    endcase
  endfunction

  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] cur_pat;
  logic              mism, last_beat, last_burst;

  // Mode 1 derives data from the beat address; all other modes run the pattern register.
  assign beat_addr  = addr_q + ADDR_W'(beat_q);
  assign cur_pat    = (mode_q == 2'd1) ? DATA_W'(beat_addr) : pat_q;
  assign mism       = (rd_data != cur_pat);
  assign last_beat  = (beat_q == LAST_BEAT);
  assign last_burst = (bcnt_q == nb_q - ADDR_W'(1));

  assign wr_req         = (state_q == WR_REQ);
  assign rd_req         = (state_q == RD_REQ);
  assign wr_addr        = addr_q;
  assign rd_addr        = addr_q;
  assign wr_data        = (state_q == WR_BEAT) ? cur_pat : '0;
  assign busy           = (state_q != IDLE) && (state_q != FIN);
  assign done           = (state_q == FIN);
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      base_q  <= '0;
      nb_q    <= '0;
      seed_q  <= '0;
      addr_q  <= '0;
      bcnt_q  <= '0;
      beat_q  <= '0;
      pat_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mode_q  <= mode;
          base_q  <= base_addr;
          nb_q    <= num_bursts;
          seed_q  <= seed;
          addr_q  <= base_addr;
          bcnt_q  <= '0;
          beat_q  <= '0;
          err_q   <= '0;
          ferr_q  <= '0;
          pat_q   <= pat_init(mode, seed);
          pass_q  <= (num_bursts == '0);
          state_q <= (num_bursts == '0) ? FIN : WR_REQ;
        end
        WR_REQ: if (wr_ack) state_q <= WR_BEAT;
        WR_BEAT: if (wr_data_en) begin
          pat_q  <= pat_next(mode_q, pat_q);
          beat_q <= beat_q + BW'(1);
          if (last_beat) begin
            beat_q <= '0;
            if (last_burst) begin
              bcnt_q  <= '0;
              addr_q  <= base_q;
              pat_q   <= pat_init(mode_q, seed_q);
              state_q <= RD_REQ;
            end else begin
              bcnt_q  <= bcnt_q + ADDR_W'(1);
              addr_q  <= addr_q + BSTEP;
              state_q <= WR_REQ;
            end
          end
        end
        RD_REQ: if (rd_ack) state_q <= RD_BEAT;
        RD_BEAT: if (rd_data_vld) begin
          pat_q  <= pat_next(mode_q, pat_q);
          beat_q <= beat_q + BW'(1);
          if (mism) begin
            if (err_q != '1) err_q <= err_q + ERR_W'(1);
            if (err_q == '0) ferr_q <= beat_addr;
          end
          if (last_beat) begin
            beat_q <= '0;
            addr_q <= addr_q + BSTEP;
            if (last_burst) begin
              // Fold the final beat's compare in so pass is already valid during done.
              pass_q  <= (err_q == '0) && !mism;
              state_q <= FIN;
            end else begin
              bcnt_q  <= bcnt_q + ADDR_W'(1);
              state_q <= RD_REQ;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Bench for sdram_traffic_gen: controller/memory model with fault injection, a write-beat
// and result scoreboard checked by a separate monitor, plus directed reset/corner cases.
`timescale 1ns/1ps
module tb_sdram_traffic_gen;
  localparam int DW = 16, AW = 21, BL = 8, EW = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [1:0] mode;
  logic [AW-1:0] base_addr, num_bursts;
  logic [DW-1:0] seed;
  logic wr_req, wr_ack, wr_data_en, rd_req, rd_ack, rd_data_vld;
  logic [AW-1:0] wr_addr, rd_addr, first_err_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic busy, done, pass;
  logic [EW-1:0] err_cnt;

  always #5 clk = ~clk;

  sdram_traffic_gen #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .num_bursts(num_bursts), .seed(seed), .wr_req(wr_req), .wr_ack(wr_ack),
    .wr_addr(wr_addr), .wr_data_en(wr_data_en), .wr_data(wr_data), .rd_req(rd_req),
    .rd_ack(rd_ack), .rd_addr(rd_addr), .rd_data_vld(rd_data_vld), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wbeat_t;
  typedef struct { logic ok; logic [EW-1:0] err; logic [AW-1:0] ferr; } res_t;

  wbeat_t exp_wr[$];
  res_t   exp_res[$];
  int total = 0, bad = 0;
  int done_cnt = 0;
  logic [DW-1:0] mem [int];
  int max_dly = 0, gap_pct = 0, fault = 0;
  int cst = 0, dly = 0, beat = 0;
  logic [AW-1:0] cur_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_init(input int m, input logic [DW-1:0] s);
    if (m == 2) return 16'h0001;
    if (m == 3) return (s == 16'h0) ? 16'h0001 : s;
    return s;
  endfunction

  function automatic logic [DW-1:0] m_next(input int m, input logic [DW-1:0] p);
    if (m == 0) return p + 16'h1;
    if (m == 2) return {p[14:0], p[15]};
    if (m == 3) return p[0] ? ((p >> 1) ^ 16'hB400) : (p >> 1);
    return p;
  endfunction

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    d = mem.exists(int'(a)) ? mem[int'(a)] : '0;
    if (fault == 1 && a == 21'h104) d[3] = 1'b1;
    if (fault == 2) d = ~d;
    return d;
  endfunction

  // Controller model: random ack latency, gapped beats, memory behind it.
  initial begin
    wr_ack = 0; wr_data_en = 0; rd_ack = 0; rd_data_vld = 0; rd_data = '0; cur_addr = '0;
    forever begin
      @(negedge clk);
      wr_ack = 0; wr_data_en = 0; rd_ack = 0; rd_data_vld = 0; rd_data = '0;
      if (rst) begin
        cst = 0; beat = 0;
      end else begin
        if (cst == 0) begin
          if (wr_req) begin
            cst = 1; dly = int'($urandom_range(0, max_dly)); cur_addr = wr_addr;
          end else if (rd_req) begin
            cst = 3; dly = int'($urandom_range(0, max_dly)); cur_addr = rd_addr;
          end
        end else if (cst == 2) begin
          if (int'($urandom_range(0, 99)) >= gap_pct) begin
            wr_data_en = 1;
            mem[int'(cur_addr + AW'(beat))] = wr_data;
            beat++;
            if (beat == BL) cst = 0;
          end
        end else if (cst == 4) begin
          if (int'($urandom_range(0, 99)) >= gap_pct) begin
            rd_data_vld = 1;
            rd_data = rd_model(cur_addr + AW'(beat));
            beat++;
            if (beat == BL) cst = 0;
          end
        end
        if (cst == 1) begin
          chk("wr_req_held", wr_req, 1);
          if (dly == 0) begin wr_ack = 1; cst = 2; beat = 0; end else dly--;
        end else if (cst == 3) begin
          chk("rd_req_held", rd_req, 1);
          if (dly == 0) begin rd_ack = 1; cst = 4; beat = 0; end else dly--;
        end
      end
    end
  end

  // Monitor: pops scoreboard entries on every write beat and on every done pulse.
  always @(negedge clk) begin
    #1;
    if (!rst && wr_data_en) begin
      if (exp_wr.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_wr_beat: got %0h expected none", wr_data);
      end else begin
        wbeat_t w;
        w = exp_wr.pop_front();
        chk("wr_data", wr_data, w.data);
        chk("wr_addr", wr_addr, w.addr);
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_res.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        res_t r;
        r = exp_res.pop_front();
        chk("pass", pass, r.ok);
        chk("err_cnt", err_cnt, r.err);
        chk("first_err_addr", first_err_addr, r.ferr);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic push_run(input int m, input logic [AW-1:0] base, input int nb,
                          input logic [DW-1:0] s, input logic ok, input logic [EW-1:0] e,
                          input logic [AW-1:0] fe);
    logic [DW-1:0] p;
    logic [AW-1:0] ba, a;
    res_t r;
    p = m_init(m, s);
    for (int b = 0; b < nb; b++) begin
      ba = base + AW'(b * BL);
      for (int i = 0; i < BL; i++) begin
        a = ba + AW'(i);
        exp_wr.push_back('{addr: ba, data: (m == 1) ? a[DW-1:0] : p});
        p = m_next(m, p);
      end
    end
    r.ok = ok; r.err = e; r.ferr = fe;
    exp_res.push_back(r);
  endtask

  task automatic pulse_start(input int m, input logic [AW-1:0] base, input int nb,
                             input logic [DW-1:0] s);
    @(negedge clk);
    start = 1; mode = 2'(m); base_addr = base; num_bursts = AW'(nb); seed = s;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run(input int m, input logic [AW-1:0] base, input int nb,
                     input logic [DW-1:0] s, input logic ok, input logic [EW-1:0] e,
                     input logic [AW-1:0] fe, input bit mid_start);
    int d0, cyc;
    push_run(m, base, nb, s, ok, e, fe);
    d0 = done_cnt;
    pulse_start(m, base, nb, s);
    chk("busy_after_start", busy, 1);
    chk("wr_req_after_start", wr_req, 1);
    cyc = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (mid_start && cyc == 20) begin
        start = 1; mode = 2'd1; base_addr = 21'h7000; num_bursts = 21'd1; seed = 16'h0;
      end
      if (mid_start && cyc == 21) start = 0;
    end
    chk("done_seen", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("pass_sticky", pass, ok);
    chk("wr_queue_drained", exp_wr.size(), 0);
  endtask

  task automatic rst_mid(input int want_cst);
    int n;
    push_run(0, 21'h3000, 4, 16'h0040, 1, 0, 0);
    pulse_start(0, 21'h3000, 4, 16'h0040);
    n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while (!(cst == want_cst && beat >= 2) && n < 5000);
    chk("reach_beat_state", n < 5000, 1);
    rst = 1;
    #1;
    chk("rst_ctl", {wr_req, rd_req, busy, done, pass}, 0);
    chk("rst_addr", {wr_addr, rd_addr}, 0);
    chk("rst_data", {wr_data, err_cnt}, 0);
    chk("rst_ferr", first_err_addr, 0);
    exp_wr.delete();
    exp_res.delete();
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1; start = 0; mode = '0; base_addr = '0; num_bursts = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {wr_req, rd_req, busy, done, pass}, 0);
    chk("reset_addr", {wr_addr, rd_addr, first_err_addr}, 0);
    chk("reset_data", {wr_data, err_cnt}, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    max_dly = 0; gap_pct = 0; fault = 0;
    run(0, 21'h0, 4, 16'h0000, 1, 0, 0, 0);

    fault = 1;
    run(1, 21'h100, 2, 16'h0, 0, 1, 21'h104, 0);
    fault = 0;

    max_dly = 5; gap_pct = 30;
    run(2, 21'h200, 16, 16'h5555, 1, 0, 0, 0);
    run(3, 21'h400, 16, 16'hACE1, 1, 0, 0, 1);

    begin
      res_t r;
      int d0;
      r.ok = 1; r.err = 0; r.ferr = 0;
      exp_res.push_back(r);
      d0 = done_cnt;
      pulse_start(0, 21'h500, 0, 16'h0);
      chk("nb0_done", done, 1);
      chk("nb0_quiet", {busy, wr_req, rd_req}, 0);
      chk("nb0_pass", pass, 1);
      @(negedge clk);
      chk("nb0_done_pulse", done, 0);
      chk("nb0_done_once", done_cnt - d0, 1);
    end

    max_dly = 2; gap_pct = 20; fault = 2;
    run(0, 21'h80, 4, 16'h1234, 0, 4'hF, 21'h80, 0);
    fault = 0;

    rst_mid(2);
    fault = 2;
    rst_mid(4);
    fault = 0;

    run(3, 21'h1000, 3, 16'h0000, 1, 0, 0, 0);
    run(1, 21'h1FFFF0, 4, 16'h0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
